fill_readout_control: RTL and testbench

Readout sequencer in the local clock domain, directly downstream of the DDR3 interface. When acquisition is disabled, it pops one fill header from the fill header FIFO and fetches that fill's 128-bit bursts one at a time through the single-burst read port. It then streams the header followed by the bursts to the readout link with a valid/ready handshake, and reports completion and timeouts.

---
 rtl/readout_pkg.sv | 30 +++
 rtl/fill_readout_control_if.sv | 16 +
 rtl/fill_readout_control.sv | 152 +++++++++++++++
 tb/tb_fill_readout_control.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared readout definitions: fill header field layout, burst address width, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The fill header layout is shared with the write controller, so field positions live only here.
package readout_pkg;

    localparam int HDR_W        = 128;
    localparam int DATA_W       = 128;
    localparam int BURST_ADDR_W = 23;

    // Fill header word: [22:0] start burst address, [38:23] burst count, [127:39] metadata.
    localparam int ADDR_LSB = 0;
    localparam int ADDR_MSB = 22;
    localparam int CNT_LSB  = 23;
    localparam int CNT_MSB  = 38;

    // Wide enough to hold the default 1024-cycle timeout limit.
    localparam int TO_CNT_W = 11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_POP      = 3'd1,
        ST_HDR_OUT  = 3'd2,
        ST_REQ      = 3'd3,
        ST_WAIT     = 3'd4,
        ST_DATA_OUT = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/fill_readout_control_if.sv
// Readout link: 128-bit words with a last marker, valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: producer holds data/valid/last while out_ready is low.
// Ports: master = producer (data, valid, last out; ready in); slave = consumer.
interface fill_readout_control_if;
    import readout_pkg::*;

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/fill_readout_control.sv
// Pops one fill header, fetches its bursts one at a time from DDR3 and streams header + bursts out.
// Latency: header valid 2 cycles after a non-empty FIFO is seen in IDLE; burst valid 1 cycle after rdy.
// Backpressure: out_ready low holds the current word; only one DDR3 request is ever outstanding.
// Ports: clk/reset_n; acq_enabled gate; FWFT header FIFO read side; DDR3 single-burst read port;
//        rd_link readout stream; fill_done pulse, sticky timeout_err, busy.
module fill_readout_control
    import readout_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    acq_enabled,
    input  logic                    fill_header_fifo_empty,
    output logic                    fill_header_fifo_rd_en,
    input  logic [HDR_W-1:0]        fill_header_fifo_out,
    output logic [BURST_ADDR_W-1:0] ddr3_rd_burst_addr,
    output logic                    ddr3_rd_one_burst,
    input  logic                    ddr3_one_burst_rdy,
    input  logic [DATA_W-1:0]       ddr3_one_burst_data,
    fill_readout_control_if.master  rd_link,
    output logic                    fill_done,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_CYC);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    remain_q;
    logic [TO_CNT_W-1:0] to_cnt_q;

    logic hdr_take;
    logic burst_take;
    logic beat_acc;
    logic to_fire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hdr_take   = 1'b0;
        burst_take = 1'b0;
        beat_acc   = 1'b0;
        to_fire    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // acq_enabled is only looked at here, so a fill in progress always completes.
                if (!acq_enabled && !fill_header_fifo_empty) begin
                    hdr_take = 1'b1;
                    state_d  = ST_POP;
                end
            end
            ST_POP: begin
                state_d = ST_HDR_OUT;
            end
            ST_HDR_OUT: begin
                if (rd_link.out_ready) begin
                    state_d = (remain_q == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A rdy in the same cycle the count hits the limit still wins.
                if (ddr3_one_burst_rdy) begin
                    burst_take = 1'b1;
                    state_d    = ST_DATA_OUT;
                end else if (to_cnt_q == TO_LIMIT) begin
                    to_fire = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DATA_OUT: begin
                if (rd_link.out_ready) begin
                    beat_acc = 1'b1;
                    state_d  = (remain_q == CNT_W'(1)) ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is a flop; control strobes are decoded from the next state so they
    // line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_header_fifo_rd_en <= 1'b0;
            ddr3_rd_one_burst      <= 1'b0;
            ddr3_rd_burst_addr     <= '0;
            rd_link.out_data       <= '0;
            rd_link.out_valid      <= 1'b0;
            rd_link.out_last       <= 1'b0;
            fill_done              <= 1'b0;
            timeout_err            <= 1'b0;
            busy                   <= 1'b0;
            remain_q               <= '0;
            to_cnt_q               <= '0;
        end else begin
            fill_header_fifo_rd_en <= (state_d == ST_POP);
            ddr3_rd_one_burst      <= (state_d == ST_REQ);
            rd_link.out_valid      <= (state_d == ST_HDR_OUT) || (state_d == ST_DATA_OUT);
            rd_link.out_last       <= ((state_d == ST_HDR_OUT)  && (remain_q == '0)) ||
                                      ((state_d == ST_DATA_OUT) && (remain_q == CNT_W'(1)));
            fill_done              <= (state_d == ST_DONE);
            busy                   <= (state_d != ST_IDLE);

            // The output register doubles as the header holding register.
            if (hdr_take) begin
                ddr3_rd_burst_addr <= fill_header_fifo_out[ADDR_MSB:ADDR_LSB];
                remain_q           <= fill_header_fifo_out[CNT_LSB +: CNT_W];
                rd_link.out_data   <= fill_header_fifo_out;
            end

            if (burst_take) begin
                rd_link.out_data <= ddr3_one_burst_data;
            end

            // Address is 23 bits wide, so the increment wraps 0x7FFFFF -> 0 on its own.
            if (beat_acc) begin
                ddr3_rd_burst_addr <= ddr3_rd_burst_addr + BURST_ADDR_W'(1);
                remain_q           <= remain_q - CNT_W'(1);
            end

            // Counter reads k in the k-th cycle after the request pulse.
            if (state_q == ST_REQ) begin
                to_cnt_q <= TO_CNT_W'(1);
            end else if (state_q == ST_WAIT) begin
                to_cnt_q <= to_cnt_q + TO_CNT_W'(1);
            end

            if (to_fire) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fill_readout_control.sv
`timescale 1ns/1ps
module tb_fill_readout_control;
    import readout_pkg::*;

    localparam int TO = 16;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         acq_enabled = 1'b0;
    logic         fill_header_fifo_empty = 1'b1;
    logic         fill_header_fifo_rd_en;
    logic [127:0] fill_header_fifo_out = '0;
    logic [22:0]  ddr3_rd_burst_addr;
    logic         ddr3_rd_one_burst;
    logic         ddr3_one_burst_rdy = 1'b0;
    logic [127:0] ddr3_one_burst_data = '0;
    logic         fill_done;
    logic         timeout_err;
    logic         busy;

    fill_readout_control_if link();

    fill_readout_control #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .acq_enabled            (acq_enabled),
        .fill_header_fifo_empty (fill_header_fifo_empty),
        .fill_header_fifo_rd_en (fill_header_fifo_rd_en),
        .fill_header_fifo_out   (fill_header_fifo_out),
        .ddr3_rd_burst_addr     (ddr3_rd_burst_addr),
        .ddr3_rd_one_burst      (ddr3_rd_one_burst),
        .ddr3_one_burst_rdy     (ddr3_one_burst_rdy),
        .ddr3_one_burst_data    (ddr3_one_burst_data),
        .rd_link                (link),
        .fill_done              (fill_done),
        .timeout_err            (timeout_err),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Model state: expected stream, expected request addresses, per-request DDR3 latency.
    logic [127:0] exp_dat_q[$];
    logic         exp_last_q[$];
    logic [22:0]  exp_addr_q[$];
    int           lat_q[$];
    logic [127:0] fifo_q[$];
    logic [22:0]  req_log[$];
    int  exp_done = 0, done_cnt = 0, pop_cnt = 0, req_cnt = 0;
    int  word_cnt = 0, last_cnt = 0;
    int  to_due = -1;
    logic to_sticky = 1'b0;
    int  pop_cyc = -1, first_valid_cyc = -1;
    int  cur_lat = 5;
    logic rand_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input logic [127:0] act);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing (t=%0t)", name, act, $time);
    endtask

    function automatic logic [127:0] data_of(input logic [22:0] a);
        return {9'h1A5, a, ~{9'h0, a}, 32'hC0DE_0000 ^ {9'h0, a}, 32'h5EED_1234 + {9'h0, a}};
    endfunction

    // Fill model: header first, then one word per burst at addr+i (mod 2^23);
    // a dropped burst (index drop) ends the fill after its request with no word.
    task automatic push_fill(input logic [22:0] a, input int n, input logic [88:0] meta, input int drop);
        int nd;
        logic [127:0] hdr;
        nd  = (drop >= 0) ? drop : n;
        hdr = {meta, n[15:0], a};
        exp_dat_q.push_back(hdr);
        exp_last_q.push_back(n == 0);
        for (int i = 0; i < nd; i++) begin
            exp_dat_q.push_back(data_of(a + 23'(i)));
            exp_last_q.push_back(i == n - 1);
        end
        for (int i = 0; i < n; i++) begin
            exp_addr_q.push_back(a + 23'(i));
            if (i == drop) begin
                lat_q.push_back(-1);
                break;
            end
            lat_q.push_back(cur_lat);
        end
        exp_done++;
        fifo_q.push_back(hdr);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget && done_cnt < exp_done; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({name, "_fill_done_count"}, done_cnt, exp_done);
        chk({name, "_words_left"}, exp_dat_q.size(), 0);
        chk({name, "_reqs_left"}, exp_addr_q.size(), 0);
        step();
    endtask

    // FWFT header FIFO
    initial begin
        logic [127:0] tmp;
        forever begin
            @(negedge clk);
            if (reset_n && fill_header_fifo_rd_en === 1'b1) begin
                chk("pop_nonempty", fifo_q.size() > 0, 1'b1);
                if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
                pop_cnt++;
                pop_cyc = cyc;
            end
            fill_header_fifo_empty = (fifo_q.size() == 0);
            if (fifo_q.size() > 0) fill_header_fifo_out = fifo_q[0];
        end
    end

    // DDR3 single-burst responder: rdy in cycle r+lat for a request in cycle r.
    initial begin
        int rd_cnt;
        int lat;
        logic [22:0] pend_addr;
        rd_cnt = -1;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            ddr3_one_burst_rdy = 1'b0;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    ddr3_one_burst_rdy  = 1'b1;
                    ddr3_one_burst_data = data_of(pend_addr);
                    rd_cnt = -1;
                end
            end
            if (reset_n && ddr3_rd_one_burst === 1'b1) begin
                req_log.push_back(ddr3_rd_burst_addr);
                req_cnt++;
                chk("one_outstanding", rd_cnt < 0, 1'b1);
                if (exp_addr_q.size() == 0) fail_now("unexpected_req", {105'h0, ddr3_rd_burst_addr});
                else chk("req_addr", ddr3_rd_burst_addr, exp_addr_q.pop_front());
                lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                if (lat < 0) begin
                    to_due = cyc + TO + 1;
                end else begin
                    rd_cnt = lat;
                    pend_addr = ddr3_rd_burst_addr;
                end
            end
        end
    end

    // Consumer ready
    initial begin
        link.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            link.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Compare process
    initial begin
        logic pv, pr, pl, pdone;
        logic [127:0] pd;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0; pdone = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pv = 1'b0;
                pdone = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", link.out_valid, 1'b1);
                    chk("hold_data", link.out_data, pd);
                    chk("hold_last", link.out_last, pl);
                end
                if (link.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (link.out_valid && link.out_ready) begin
                    word_cnt++;
                    if (link.out_last) last_cnt++;
                    if (exp_dat_q.size() == 0) begin
                        fail_now("unexpected_word", link.out_data);
                    end else begin
                        chk("word_data", link.out_data, exp_dat_q.pop_front());
                        chk("word_last", link.out_last, exp_last_q.pop_front());
                    end
                end
                pv = link.out_valid; pr = link.out_ready; pd = link.out_data; pl = link.out_last;
                if (to_due >= 0 && cyc >= to_due) to_sticky = 1'b1;
                chk("timeout_err", timeout_err, to_sticky);
                if (fill_done) begin
                    done_cnt++;
                    chk("fill_done_single_cycle", pdone, 1'b0);
                end
                pdone = fill_done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_all_zero(input string name);
        chk({name, "_rd_en"}, fill_header_fifo_rd_en, 1'b0);
        chk({name, "_one_burst"}, ddr3_rd_one_burst, 1'b0);
        chk({name, "_burst_addr"}, ddr3_rd_burst_addr, 23'h0);
        chk({name, "_out_data"}, link.out_data, 128'h0);
        chk({name, "_out_valid"}, link.out_valid, 1'b0);
        chk({name, "_out_last"}, link.out_last, 1'b0);
        chk({name, "_fill_done"}, fill_done, 1'b0);
        chk({name, "_timeout_err"}, timeout_err, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int w0, l0, p0, r0, push_cyc;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset_n = 1'b1;
        step();

        // 1: addr 0x100, N=3, rdy 5 cycles after each request
        cur_lat = 5;
        w0 = word_cnt; l0 = last_cnt; p0 = pop_cnt; req_log.delete();
        first_valid_cyc = -1; push_cyc = cyc;
        push_fill(23'h000100, 3, {25'h0ABCDEF, 64'hDEAD_BEEF_0000_0001}, -1);
        wait_done("t1", 200);
        chk("t1_req_count", req_log.size(), 3);
        if (req_log.size() == 3) begin
            chk("t1_req_addr0", req_log[0], 23'h000100);
            chk("t1_req_addr1", req_log[1], 23'h000101);
            chk("t1_req_addr2", req_log[2], 23'h000102);
        end
        chk("t1_word_count", word_cnt - w0, 4);
        chk("t1_last_count", last_cnt - l0, 1);
        chk("t1_pop_count", pop_cnt - p0, 1);
        chk("t1_pop_latency", pop_cyc, push_cyc + 1);
        chk("t1_hdr_valid_latency", first_valid_cyc, pop_cyc + 1);

        // 2: N=0 header only
        w0 = word_cnt; l0 = last_cnt; req_log.delete();
        push_fill(23'h0002AB, 0, {25'h1555555, 64'h0123_4567_89AB_CDEF}, -1);
        wait_done("t2", 50);
        chk("t2_req_count", req_log.size(), 0);
        chk("t2_word_count", word_cnt - w0, 1);
        chk("t2_last_count", last_cnt - l0, 1);

        // 3: address wrap
        cur_lat = 1;
        req_log.delete();
        push_fill(23'h7FFFFE, 3, {25'h0000001, 64'hFFFF_0000_FFFF_0000}, -1);
        wait_done("t3", 100);
        chk("t3_req_count", req_log.size(), 3);
        if (req_log.size() == 3) begin
            chk("t3_req_addr0", req_log[0], 23'h7FFFFE);
            chk("t3_req_addr1", req_log[1], 23'h7FFFFF);
            chk("t3_req_addr2", req_log[2], 23'h000000);
        end

        // 4a: rdy in the very cycle the count reaches the limit still wins
        cur_lat = TO;
        push_fill(23'h000040, 1, {25'h0000002, 64'h1111_2222_3333_4444}, -1);
        wait_done("t4a", 100);
        chk("t4a_no_timeout", timeout_err, 1'b0);

        // 4: second burst never answered
        cur_lat = 5;
        push_fill(23'h000200, 3, {25'h0000003, 64'h5555_6666_7777_8888}, 1);
        wait_done("t4", 200);
        chk("t4_timeout_set", timeout_err, 1'b1);
        push_fill(23'h000300, 2, {25'h0000004, 64'h9999_AAAA_BBBB_CCCC}, -1);
        wait_done("t4b", 200);
        chk("t4b_timeout_sticky", timeout_err, 1'b1);

        // 5: random backpressure, acq_enabled rising mid-fill
        cur_lat = 2;
        rand_mode = 1'b1;
        w0 = word_cnt;
        p0 = pop_cnt;
        push_fill(23'h000500, 4, {25'h0000005, 64'hDDDD_EEEE_FFFF_0000}, -1);
        for (int i = 0; i < 50 && pop_cnt == p0; i++) step();
        chk("t5_pop_seen", pop_cnt - p0, 1);
        acq_enabled = 1'b1;
        wait_done("t5", 400);
        chk("t5_word_count", word_cnt - w0, 5);
        rand_mode = 1'b0;
        p0 = pop_cnt;
        push_fill(23'h000600, 1, {25'h0000006, 64'h0F0F_0F0F_F0F0_F0F0}, -1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_acq_busy", busy, 1'b0);
            chk("t5_acq_rd_en", fill_header_fifo_rd_en, 1'b0);
        end
        chk("t5_acq_no_pop", pop_cnt - p0, 0);
        step();
        acq_enabled = 1'b0;
        wait_done("t5b", 100);

        // 6: reset during WAIT
        cur_lat = 5;
        r0 = req_cnt;
        push_fill(23'h000700, 3, {25'h0000007, 64'hAAAA_5555_AAAA_5555}, -1);
        for (int i = 0; i < 50 && req_cnt == r0; i++) step();
        chk("t6_req_seen", req_cnt - r0, 1);
        step();
        reset_n = 1'b0;
        #1;
        check_all_zero("t6_async_reset");
        exp_dat_q.delete(); exp_last_q.delete(); exp_addr_q.delete(); lat_q.delete();
        exp_done = done_cnt; to_sticky = 1'b0; to_due = -1;
        step();
        reset_n = 1'b1;
        w0 = word_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_idle_busy", busy, 1'b0);
            chk("t6_idle_valid", link.out_valid, 1'b0);
        end
        chk("t6_no_words", word_cnt - w0, 0);
        step();
        w0 = word_cnt;
        push_fill(23'h7FFFF0, 2, {25'h0000008, 64'h1357_9BDF_2468_ACE0}, -1);
        wait_done("t6b", 200);
        chk("t6b_word_count", word_cnt - w0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
